prio_dec: RTL

//   Inverse of the priority encoder: rebuilds a WIDTH-bit mask from a stream of
//   8-bit bit indices. Each accepted index is decoded to one-hot and ORed into an

---
 rtl/prio_dec_if.sv | 25 ++
 rtl/prio_dec.sv | 80 ++++++++
 2 files changed

// File: rtl/prio_dec_if.sv
// Index-stream in / mask-stream out bundle for prio_dec.
// The slave modport is the decoder side and the master modport is the producer/consumer side.
interface prio_dec_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_idx;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_mask;
    logic [8:0]       out_cnt;
    logic             out_err;

    modport master (
        output in_valid, in_idx, in_last, out_ready,
        input  in_ready, out_valid, out_mask, out_cnt, out_err
    );

    modport slave (
        input  in_valid, in_idx, in_last, out_ready,
        output in_ready, out_valid, out_mask, out_cnt, out_err
    );
endinterface

// File: rtl/prio_dec.sv
// Priority decoder: ORs a stream of bit indices into a WIDTH-bit mask.
// The mask is presented on a valid/ready port once the last beat has been accepted.
module prio_dec #(
    parameter  int WIDTH_LOG = 4,
    localparam int WIDTH     = 1 << WIDTH_LOG
) (
    input  logic      clk,
    input  logic      rst,
    prio_dec_if.slave bus
);
    if (WIDTH_LOG < 1 || WIDTH_LOG > 8) begin : g_bad_width
        $error("prio_dec: WIDTH_LOG must be in 1..8");
    end

    typedef enum logic {ACCUM, OUT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [8:0]       cnt, cnt_nxt;
    logic             err, err_nxt;
    logic [WIDTH-1:0] onehot;
    logic             in_rng, dup, accept;

    // The compare uses 9 bits so that WIDTH=256 puts every 8-bit index in range.
    assign in_rng = {1'b0, bus.in_idx} < 9'(WIDTH);

    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign onehot[i] = (bus.in_idx == 8'(i));
    end

    assign dup    = |(acc & onehot);
    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        err_nxt   = err;
        case (state)
            ACCUM: begin
                if (accept) begin
                    if (!in_rng || dup) err_nxt = 1'b1;
                    else                acc_nxt = acc | onehot;
                    cnt_nxt = (cnt == 9'd511) ? cnt : cnt + 9'd1;
                    if (bus.in_last) state_nxt = OUT;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    // The outputs come only from registers, so there is no combinational path from in_* to out_*.
    assign bus.in_ready  = (state == ACCUM) && !rst;
    assign bus.out_valid = (state == OUT);
    assign bus.out_mask  = acc;
    assign bus.out_cnt   = cnt;
    assign bus.out_err   = err;
endmodule
